cmos_pattern_gen: RTL and testbench
===================================

Name: cmos_pattern_gen

Overview:
Parametrised CMOS camera timing and pattern generator for simulation and on-board bring-up of capture pipelines such as the median filter and other image filters. It produces pclk/vsync/href/data in DVP style. It generalises the fixed single-pattern simulator with:
- configurable blanking and data width
- 1- or 2-byte-per-pixel (RAW / RGB565-style) output
- four selectable test patterns
- start/stop control, a frame counter and a frame-done pulse

Parameters:
DATA_WIDTH, 8, cmos_data bus width.
BPP, 1, bus beats per pixel (1 or 2); pixel word PIX_W = DATA_WIDTH*BPP.
IMG_HDISP, 640, active pixels per line.
IMG_VDISP, 480, active lines per frame.
H_SYNC / H_BACK / H_FRONT, 5 / 5 / 5, horizontal blanking in clocks.
V_SYNC / V_BACK / V_FRONT, 1 / 0 / 1, vertical blanking in lines.
CMOS_VSYNC_VALID, 1'b1, 1: vsync low in sync rows and high otherwise; 0: inverted.
CHK_SHIFT, 3, checkerboard cell size = 2^CHK_SHIFT pixels.

Ports:
clk  in  1  generator clock (sensor xclk)
rst  in  1  synchronous reset, active-high
enable  in  1  run request, sampled at frame boundaries
pattern_sel  in  2  0 h-ramp, 1 v-ramp, 2 checkerboard, 3 moving diagonal
cmos_pclk  out  1  ~clk; data is stable on the cmos_pclk rising edge
cmos_vsync  out  1  frame sync, polarity per CMOS_VSYNC_VALID
cmos_href  out  1  line valid, high during active beats
cmos_data  out  DATA_WIDTH  pixel beat
frame_cnt  out  16  completed frames, wraps at 0xFFFF
frame_done  out  1  one-clock pulse per completed frame

Behaviour:
- Derived constants: H_DISP = IMG_HDISP*BPP clocks; H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT; V_TOTAL = V_SYNC+V_BACK+IMG_VDISP+V_FRONT.
- Counters hcnt (clocks) and vcnt (lines), 12 bits each.
- FSM has two states, IDLE and RUN.
  - IDLE: counters held at 0; vsync_r=0, so cmos_vsync sits at sync level; href=0; data=0.
  - IDLE with enable=1: next cycle goes to RUN with hcnt=vcnt=0, and pattern_sel is latched.
  - RUN: hcnt counts 0..H_TOTAL-1; vcnt increments when hcnt=H_TOTAL-1.
  - RUN at the last position (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1): frame_cnt increments and frame_done pulses in the next cycle.
  - From that last position: if enable=1, wrap to 0/0 and re-latch pattern_sel; else go to IDLE.
  - enable falling mid-frame never truncates the frame.
- Outputs are registered from the counter values: one clock of latency.
  - vsync_r = (vcnt >= V_SYNC).
  - href = active window: vcnt in [V_SYNC+V_BACK, +IMG_VDISP) and hcnt in [H_SYNC+H_BACK, +H_DISP).
  - data = 0 outside the active window.
- Pixel coordinates: x = (hcnt-H_SYNC-H_BACK)/BPP; y = vcnt-V_SYNC-V_BACK. The pixel value is truncated to PIX_W.
  - Mode 0: x.
  - Mode 1: y.
  - Mode 2: all ones if ((x>>CHK_SHIFT) ^ (y>>CHK_SHIFT))[0] is set, else 0.
  - Mode 3: x+y+frame_cnt, modulo 2^PIX_W.
- BPP=2: most-significant beat first, then the least-significant beat.
- Reset at any time returns to IDLE: counters 0, frame_cnt 0, frame_done 0, and all outputs at their IDLE values on the following cycle.
- pattern_sel changes mid-frame are ignored until the next latch point.

Optional Feature:
Macro CMOS_FRAME_SUM_EN.
- Defined: adds output frame_sum (16 bits).
  - Internal accumulator sums every active cmos_data beat, modulo 2^16.
  - frame_sum is loaded in the same cycle frame_done pulses; the accumulator clears at each frame start.
  - Reset clears both to 0.
- Undefined: no frame_sum port, no accumulator logic.

Decomposition:
- Shared package cmos_sim_pkg holds:
  - the pattern enum (PAT_HRAMP=0, PAT_VRAMP=1, PAT_CHECK=2, PAT_DIAG=3)
  - the FSM state typedef (ST_IDLE, ST_RUN)
  - a function computing H_TOTAL/V_TOTAL from the blanking parameters
- One natural sub-module, cmos_pattern_pix: combinational pixel value from x, y, frame_cnt and the latched mode, plus beat selection.

Test Plan:
All scenarios use IMG_HDISP=16, IMG_VDISP=4, default blanking, so H_TOTAL=31, V_TOTAL=6 and a frame is 186 clocks.
1. BPP=1, mode 0, enable held high after rst release:
   - href first high 42 clocks after the IDLE→RUN transition;
   - data 0,1,…,15 over 16 consecutive clocks;
   - 4 href pulses per frame; frame_done every 186 clocks; frame_cnt 1,2,3.
2. Mode 2 with CHK_SHIFT=3: line 0 data is 0×8 then 0xFF×8; lines 0–3 identical.
3. BPP=2, mode 3, frame_cnt=1: H_TOTAL=47; per pixel two beats; pixel x=5 on line y=2 gives beats 0x00, 0x08.
4. Lower enable at line 2 of frame 0:
   - frame completes; one frame_done; FSM enters IDLE;
   - cmos_vsync at sync level, href=0;
   - re-raise enable → new frame starts the next cycle with hcnt=0.
5. pattern_sel changed 0→1 mid-frame: data stays h-ramp until wrap; the next frame outputs the line index 0..3.
6. rst pulsed mid-line during href: next cycle href=0, data=0, frame_cnt=0; with CMOS_FRAME_SUM_EN, mode 0 BPP=1 gives frame_sum = 4×120 = 480.

Source files
------------

// File: rtl/cmos_sim_pkg.sv
// -----------------------------------------------------------------------------
// cmos_sim_pkg
// Shared types and helpers for the CMOS timing/pattern generator.
//   pattern_e   : test-pattern selector encoding
//   state_e     : generator FSM states
//   calc_total  : total period (clocks or lines) from sync/back/display/front
// -----------------------------------------------------------------------------
package cmos_sim_pkg;

  typedef enum logic [1:0] {
    PAT_HRAMP = 2'd0,
    PAT_VRAMP = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_DIAG  = 2'd3
  } pattern_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Width of the horizontal and vertical position counters.
  localparam int CNT_W = 12;

  function automatic int calc_total(input int sync_len, input int back_len,
                                    input int disp_len, input int front_len);
    return sync_len + back_len + disp_len + front_len;
  endfunction

endpackage

// File: rtl/cmos_pattern_pix.sv
// -----------------------------------------------------------------------------
// cmos_pattern_pix
// Combinational pixel generator: turns the position inside the active window
// into the bus beat for the latched test pattern.
// Ports:
//   hoff      in  CNT_W       beat offset from the first active clock of a line
//   y         in  CNT_W       active line index
//   frame_cnt in  16          completed-frame count (moves the diagonal)
//   mode      in  pattern_e   latched pattern
//   beat      out DATA_WIDTH  bus beat (MS beat first when BPP=2)
// -----------------------------------------------------------------------------
module cmos_pattern_pix
  import cmos_sim_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BPP        = 1,
  parameter int CHK_SHIFT  = 3
) (
  input  logic [CNT_W-1:0]      hoff,
  input  logic [CNT_W-1:0]      y,
  input  logic [15:0]           frame_cnt,
  input  pattern_e              mode,
  output logic [DATA_WIDTH-1:0] beat
);

  localparam int PIX_W = DATA_WIDTH * BPP;
  // The diagonal sum is formed wide enough to hold frame_cnt, then truncated.
  localparam int SUM_W = (PIX_W > 16) ? PIX_W : 16;

  logic [CNT_W-1:0] x;
  logic [SUM_W-1:0] diag;
  logic             chk;
  logic [PIX_W-1:0] pix;

  // Two beats per pixel: drop the beat-select bit to get the pixel column.
  assign x    = (BPP == 2) ? {1'b0, hoff[CNT_W-1:1]} : hoff;
  assign diag = SUM_W'(x) + SUM_W'(y) + SUM_W'(frame_cnt);
  // Bit CHK_SHIFT of each coordinate is bit 0 of its cell index.
  assign chk  = x[CHK_SHIFT] ^ y[CHK_SHIFT];

  always_comb begin
    pix = '0;
    unique case (mode)
      PAT_HRAMP: pix = PIX_W'(x);
      PAT_VRAMP: pix = PIX_W'(y);
      PAT_CHECK: pix = {PIX_W{chk}};
      PAT_DIAG:  pix = PIX_W'(diag);
    endcase
  end

  if (BPP == 2) begin : g_two_beat
    assign beat = hoff[0] ? pix[DATA_WIDTH-1:0] : pix[PIX_W-1 -: DATA_WIDTH];
  end else begin : g_one_beat
    assign beat = pix;
  end

endmodule

// File: rtl/cmos_pattern_gen.sv
// -----------------------------------------------------------------------------
// cmos_pattern_gen
// DVP-style CMOS sensor timing and test-pattern generator.
// Optional build macro: CMOS_FRAME_SUM_EN adds the frame_sum checksum output.
// Ports:
//   clk          in   1           generator clock (sensor xclk)
//   rst          in   1           synchronous reset, active-high
//   enable       in   1           run request, sampled at frame boundaries
//   pattern_sel  in   2           0 h-ramp, 1 v-ramp, 2 checkerboard, 3 diagonal
//   cmos_pclk    out  1           ~clk, data stable on its rising edge
//   cmos_vsync   out  1           frame sync, polarity from CMOS_VSYNC_VALID
//   cmos_href    out  1           high during active beats
//   cmos_data    out  DATA_WIDTH  pixel beat
//   frame_cnt    out  16          completed frames (wraps)
//   frame_done   out  1           one-clock pulse per completed frame
//   frame_sum    out  16          (CMOS_FRAME_SUM_EN) sum of last frame's beats
// -----------------------------------------------------------------------------
module cmos_pattern_gen
  import cmos_sim_pkg::*;
#(
  parameter int   DATA_WIDTH       = 8,
  parameter int   BPP              = 1,
  parameter int   IMG_HDISP        = 640,
  parameter int   IMG_VDISP        = 480,
  parameter int   H_SYNC           = 5,
  parameter int   H_BACK           = 5,
  parameter int   H_FRONT          = 5,
  parameter int   V_SYNC           = 1,
  parameter int   V_BACK           = 0,
  parameter int   V_FRONT          = 1,
  parameter logic CMOS_VSYNC_VALID = 1'b1,
  parameter int   CHK_SHIFT        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  output logic                  cmos_pclk,
  output logic                  cmos_vsync,
  output logic                  cmos_href,
  output logic [DATA_WIDTH-1:0] cmos_data,
  output logic [15:0]           frame_cnt,
  output logic                  frame_done
`ifdef CMOS_FRAME_SUM_EN
  ,
  output logic [15:0]           frame_sum
`endif
);

  localparam int H_DISP  = IMG_HDISP * BPP;
  localparam int H_TOTAL = calc_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int V_TOTAL = calc_total(V_SYNC, V_BACK, IMG_VDISP, V_FRONT);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_SYNC_L = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_LO = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_HI = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_HI = CNT_W'(V_SYNC + V_BACK + IMG_VDISP);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] hcnt, hcnt_nxt;
  logic [CNT_W-1:0] vcnt, vcnt_nxt;
  logic             mode_load;
  pattern_e         mode_q;

  logic             run;
  logic             line_end;
  logic             frame_end;
  logic             active;
  logic [CNT_W-1:0] hoff;
  logic [CNT_W-1:0] ypos;
  logic [DATA_WIDTH-1:0] beat;
  logic             vsync_r;

  assign run       = (state == ST_RUN);
  assign line_end  = (hcnt == H_LAST);
  assign frame_end = line_end && (vcnt == V_LAST);
  assign active    = (vcnt >= V_ACT_LO) && (vcnt < V_ACT_HI) &&
                     (hcnt >= H_ACT_LO) && (hcnt < H_ACT_HI);
  assign hoff      = hcnt - H_ACT_LO;
  assign ypos      = vcnt - V_ACT_LO;

  // ---------------------------------------------------------------------------
  // FSM: next state and counter updates
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    hcnt_nxt  = hcnt;
    vcnt_nxt  = vcnt;
    mode_load = 1'b0;
    unique case (state)
      ST_IDLE: begin
        hcnt_nxt = '0;
        vcnt_nxt = '0;
        if (enable) begin
          state_nxt = ST_RUN;
          mode_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (frame_end) begin
          // Frame boundary is the only point where enable and pattern_sel act.
          hcnt_nxt = '0;
          vcnt_nxt = '0;
          if (enable) mode_load = 1'b1;
          else        state_nxt = ST_IDLE;
        end else if (line_end) begin
          hcnt_nxt = '0;
          vcnt_nxt = vcnt + 1'b1;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      hcnt   <= '0;
      vcnt   <= '0;
      mode_q <= PAT_HRAMP;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      vcnt  <= vcnt_nxt;
      if (mode_load) mode_q <= pattern_e'(pattern_sel);
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel generation
  // ---------------------------------------------------------------------------
  cmos_pattern_pix #(
    .DATA_WIDTH (DATA_WIDTH),
    .BPP        (BPP),
    .CHK_SHIFT  (CHK_SHIFT)
  ) u_pix (
    .hoff      (hoff),
    .y         (ypos),
    .frame_cnt (frame_cnt),
    .mode      (mode_q),
    .beat      (beat)
  );

  // ---------------------------------------------------------------------------
  // Registered outputs: one clock behind the counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_r    <= 1'b0;
      cmos_href  <= 1'b0;
      cmos_data  <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      vsync_r    <= run && (vcnt >= V_SYNC_L);
      cmos_href  <= run && active;
      cmos_data  <= (run && active) ? beat : '0;
      frame_done <= run && frame_end;
      if (run && frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign cmos_pclk  = ~clk;
  assign cmos_vsync = CMOS_VSYNC_VALID ? vsync_r : ~vsync_r;

`ifdef CMOS_FRAME_SUM_EN
  // ---------------------------------------------------------------------------
  // Per-frame checksum of every active beat, published with frame_done
  // ---------------------------------------------------------------------------
  logic [15:0] sum_acc;
  logic [15:0] sum_add;

  // The beat computed now is the cmos_data of the next cycle; adding it here
  // keeps the sum aligned with frame_done even if the last position is active.
  assign sum_add = (run && active) ? 16'(beat) : 16'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_acc   <= '0;
      frame_sum <= '0;
    end else if (!run) begin
      sum_acc <= '0;
    end else if (frame_end) begin
      frame_sum <= sum_acc + sum_add;
      sum_acc   <= '0;
    end else begin
      sum_acc <= sum_acc + sum_add;
    end
  end
`endif

endmodule

// File: tb/tb_cmos_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_cmos_pattern_gen
// Two generators (BPP=1 and BPP=2, 16x4 image, default blanking) driven side by
// side. A frame-position model predicts every output from the current position
// in the frame using plain row/column arithmetic.
// -----------------------------------------------------------------------------
module tb_cmos_pattern_gen;

  localparam int HD     = 16;
  localparam int VD     = 4;
  localparam int HBLANK = 15;      // H_SYNC + H_BACK + H_FRONT
  localparam int HSTART = 10;      // H_SYNC + H_BACK
  localparam int VT     = 6;       // V_SYNC + V_BACK + VD + V_FRONT

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en1, en2;
  logic [1:0] sel1, sel2;
  logic       pclk1, vs1, href1, fd1;
  logic       pclk2, vs2, href2, fd2;
  logic [7:0] data1, data2;
  logic [15:0] fc1, fc2;
`ifdef CMOS_FRAME_SUM_EN
  logic [15:0] fs1, fs2;
`endif

  cmos_pattern_gen #(.DATA_WIDTH(8), .BPP(1), .IMG_HDISP(HD), .IMG_VDISP(VD)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .pattern_sel(sel1),
    .cmos_pclk(pclk1), .cmos_vsync(vs1), .cmos_href(href1), .cmos_data(data1),
    .frame_cnt(fc1), .frame_done(fd1)
`ifdef CMOS_FRAME_SUM_EN
    , .frame_sum(fs1)
`endif
  );

  cmos_pattern_gen #(.DATA_WIDTH(8), .BPP(2), .IMG_HDISP(HD), .IMG_VDISP(VD)) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .pattern_sel(sel2),
    .cmos_pclk(pclk2), .cmos_vsync(vs2), .cmos_href(href2), .cmos_data(data2),
    .frame_cnt(fc2), .frame_done(fd2)
`ifdef CMOS_FRAME_SUM_EN
    , .frame_sum(fs2)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state, index 0 -> BPP=1, index 1 -> BPP=2
  int m_run [2];
  int m_pos [2];   // linear position inside the frame
  int m_mode[2];
  int m_fc  [2];
  int m_acc [2];
  int m_fs  [2];

  function automatic int htot(input int bpp);
    return HBLANK + HD * bpp;
  endfunction

  // Outputs that the counter position 'pos' produces one clock later.
  function automatic void pix_model(input int bpp, input int pos, input int mode,
                                    input int fc, output bit vs, output bit hr,
                                    output int d);
    int row, col, x, y, pix, mask;
    row  = pos / htot(bpp);
    col  = pos % htot(bpp);
    vs   = (row >= 1);
    hr   = (row >= 1) && (row < 1 + VD) && (col >= HSTART) && (col < HSTART + HD * bpp);
    d    = 0;
    mask = (1 << (8 * bpp)) - 1;
    if (hr) begin
      x = (col - HSTART) / bpp;
      y = row - 1;
      case (mode)
        0:       pix = x;
        1:       pix = y;
        2:       pix = (((x >> 3) ^ (y >> 3)) & 1) ? mask : 0;
        default: pix = x + y + fc;
      endcase
      pix = pix & mask;
      if (bpp == 2) d = (((col - HSTART) % 2) == 0) ? (pix >> 8) : (pix & 8'hFF);
      else          d = pix;
    end
  endfunction

  // One clock: predict from pre-edge inputs/state, advance, compare #1 later.
  task automatic step();
    logic [31:0] e_vs[2], e_hr[2], e_d[2], e_fd[2], e_fc[2], e_fs[2];
    logic [31:0] o_vs[2], o_hr[2], o_d[2], o_fd[2], o_fc[2], o_fs[2];
    bit en_in[2];
    int sel_in[2];
    en_in[0]  = en1;
    en_in[1]  = en2;
    sel_in[0] = int'(sel1);
    sel_in[1] = int'(sel2);
    for (int i = 0; i < 2; i++) begin
      bit vs, hr;
      int d, len;
      len = htot(i + 1) * VT;
      vs = 0; hr = 0; d = 0;
      e_fd[i] = 0;
      if (m_run[i] != 0) pix_model(i + 1, m_pos[i], m_mode[i], m_fc[i], vs, hr, d);
      if (rst) begin
        vs = 0; hr = 0; d = 0;
        m_run[i] = 0; m_pos[i] = 0; m_fc[i] = 0; m_acc[i] = 0; m_fs[i] = 0;
      end else begin
        if (hr) m_acc[i] = (m_acc[i] + d) & 16'hFFFF;
        if (m_run[i] == 0) begin
          m_acc[i] = 0;
          if (en_in[i]) begin
            m_run[i] = 1; m_pos[i] = 0; m_mode[i] = sel_in[i];
          end
        end else if (m_pos[i] == len - 1) begin
          e_fd[i] = 1;
          m_fc[i] = (m_fc[i] + 1) & 16'hFFFF;
          m_fs[i] = m_acc[i];
          m_acc[i] = 0;
          m_pos[i] = 0;
          if (en_in[i]) m_mode[i] = sel_in[i];
          else          m_run[i] = 0;
        end else begin
          m_pos[i]++;
        end
      end
      e_vs[i] = vs; e_hr[i] = hr; e_d[i] = d;
      e_fc[i] = m_fc[i]; e_fs[i] = m_fs[i];
    end
    @(posedge clk);
    #1;
    o_vs[0] = vs1; o_hr[0] = href1; o_d[0] = data1; o_fd[0] = fd1; o_fc[0] = fc1;
    o_vs[1] = vs2; o_hr[1] = href2; o_d[1] = data2; o_fd[1] = fd2; o_fc[1] = fc2;
`ifdef CMOS_FRAME_SUM_EN
    o_fs[0] = fs1; o_fs[1] = fs2;
`else
    o_fs[0] = 0;   o_fs[1] = 0;
`endif
    for (int i = 0; i < 2; i++) begin
      check($sformatf("bpp%0d.vsync", i + 1), o_vs[i], e_vs[i]);
      check($sformatf("bpp%0d.href", i + 1),  o_hr[i], e_hr[i]);
      check($sformatf("bpp%0d.data", i + 1),  o_d[i],  e_d[i]);
      check($sformatf("bpp%0d.fdone", i + 1), o_fd[i], e_fd[i]);
      check($sformatf("bpp%0d.fcnt", i + 1),  o_fc[i], e_fc[i]);
`ifdef CMOS_FRAME_SUM_EN
      check($sformatf("bpp%0d.fsum", i + 1),  o_fs[i], e_fs[i]);
`endif
    end
    check("pclk", {31'd0, pclk1}, 32'd0);
  endtask

  initial begin
    int first_href, fd_prev, fd_count;
    bit found;
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_pos[i] = 0; m_mode[i] = 0; m_fc[i] = 0; m_acc[i] = 0; m_fs[i] = 0;
    end

    // Reset state
    rst = 1'b1; en1 = 1'b0; en2 = 1'b0; sel1 = 2'd0; sel2 = 2'd0;
    repeat (3) step();
    check("rst.fcnt", {16'd0, fc1}, 32'd0);
    check("rst.href", {31'd0, href1}, 32'd0);

    // Free-running frames: h-ramp on BPP=1, diagonal on BPP=2; mid-frame
    // pattern changes on BPP=1 take effect only at the next frame.
    rst = 1'b0; en1 = 1'b1; en2 = 1'b1; sel1 = 2'd0; sel2 = 2'd3;
    step();                        // IDLE -> RUN edge
    first_href = -1;
    fd_prev    = -1;
    for (int n = 1; n <= 940; n++) begin
      if (n == 400) sel1 = 2'd1;
      if (n == 700) sel1 = 2'd2;
      step();
      if (href1 && first_href < 0) first_href = n;
      if (fd1) begin
        if (fd_prev >= 0) check("fdone.gap", n - fd_prev, 186);
        fd_prev = n;
      end
      if (n == 444) check("bpp2.x5y2.msb", {24'd0, data2}, 32'h00);
      if (n == 445) check("bpp2.x5y2.lsb", {24'd0, data2}, 32'h08);
`ifdef CMOS_FRAME_SUM_EN
      if (n == 186) check("fsum.hramp", {16'd0, fs1}, 32'd480);
`endif
    end
    check("href.latency", first_href, 42);

    // Drop enable at line 2: frame completes once, then idle; then restart.
    found = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      step();
      if (m_run[0] != 0 && m_pos[0] == 2 * htot(1)) found = 1;
    end
    check("wait.line2", {31'd0, found}, 32'd1);
    en1 = 1'b0;
    fd_count = 0;
    for (int n = 0; n < 300; n++) begin
      step();
      if (fd1) fd_count++;
    end
    check("drop.fdone_count", fd_count, 1);
    check("idle.href", {31'd0, href1}, 32'd0);
    check("idle.vsync", {31'd0, vs1}, 32'd0);
    en1 = 1'b1;
    repeat (200) step();

    // Randomized pattern selection and occasional enable drops.
    for (int n = 0; n < 3000; n++) begin
      sel1 = 2'($urandom_range(0, 3));
      sel2 = 2'($urandom_range(0, 3));
      en1  = ($urandom_range(0, 49) != 0);
      en2  = ($urandom_range(0, 49) != 0);
      step();
    end

    // Reset pulsed while href is high.
    en1 = 1'b1; en2 = 1'b1; sel1 = 2'd0;
    found = 0;
    for (int n = 0; n < 600 && !found; n++) begin
      step();
      if (href1) found = 1;
    end
    check("wait.href", {31'd0, found}, 32'd1);
    rst = 1'b1;
    step();
    check("rst.mid.href", {31'd0, href1}, 32'd0);
    check("rst.mid.data", {24'd0, data1}, 32'd0);
    check("rst.mid.fcnt", {16'd0, fc1}, 32'd0);
    rst = 1'b0;
    repeat (800) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
